// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch controller.
// Holds the PC, issues one instruction-memory read at a time, and hands
// returned words to decode. A one-entry skid buffer absorbs a word that
// returns while decode is stalled. Branch/jump redirects (branch wins)
// flush the fetch stream. A misaligned target raises a one-cycle exception
// pulse and vectors to EXC_VEC instead.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic        imem_req_r;
    logic        pend_valid_r, pend_valid_nxt_s;
    logic [31:0] pend_pc_r, pend_pc_nxt_s;
    logic        skid_valid_r, skid_valid_nxt_s;
    logic [31:0] skid_pc_r, skid_pc_nxt_s;
    logic [31:0] skid_instr_r, skid_instr_nxt_s;
    logic        if_valid_r, if_valid_nxt_s;
    logic [31:0] if_pc_r, if_pc_nxt_s;
    logic [31:0] if_instr_r, if_instr_nxt_s;
    logic [31:0] if_pc_plus4_r, if_pc_plus4_nxt_s;
    logic        misalign_r;

    logic        redir_s;
    logic [31:0] raw_tgt_s;
    logic        misal_s;
    logic [31:0] tgt_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] skid_pc_plus4_s;

    // Resolve the redirect source and replace a misaligned target by the exception vector.
    always_comb begin
        redir_s   = br_taken | jmp;
        raw_tgt_s = br_taken ? br_target : jmp_target;
        misal_s   = redir_s & (raw_tgt_s[1:0] != 2'b00);
        if (misal_s) begin
            tgt_s = EXC_VEC;
        end else begin
            tgt_s = raw_tgt_s;
        end
    end

    // Sequential address arithmetic wraps modulo 2^32 (carry dropped by the width).
    assign pc_plus4_s      = pc_r + 32'd4;
    assign skid_pc_plus4_s = skid_pc_r + 32'd4;

    // Next-state, PC, pending-redirect, skid and decode-bundle computation.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        pend_valid_nxt_s  = pend_valid_r;
        pend_pc_nxt_s     = pend_pc_r;
        skid_valid_nxt_s  = skid_valid_r;
        skid_pc_nxt_s     = skid_pc_r;
        skid_instr_nxt_s  = skid_instr_r;
        if_valid_nxt_s    = if_valid_r;
        if_pc_nxt_s       = if_pc_r;
        if_instr_nxt_s    = if_instr_r;
        if_pc_plus4_nxt_s = if_pc_plus4_r;

        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_REQ;
                if (redir_s) begin
                    pc_nxt_s       = tgt_s;
                    if_valid_nxt_s = 1'b0;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end

            ST_REQ: begin
                if (imem_ack) begin
                    if (redir_s) begin
                        // Same-cycle redirect: drop the returned word, newest target wins.
                        pc_nxt_s         = tgt_s;
                        pend_valid_nxt_s = 1'b0;
                        if_valid_nxt_s   = 1'b0;
                    end else if (pend_valid_r) begin
                        // Word belongs to the wrong path; retire it and follow the pending target.
                        pc_nxt_s         = pend_pc_r;
                        pend_valid_nxt_s = 1'b0;
                        if (!stall) begin
                            if_valid_nxt_s = 1'b0;
                        end else begin
                            if_valid_nxt_s = if_valid_r;
                        end
                    end else if (stall) begin
                        skid_valid_nxt_s = 1'b1;
                        skid_pc_nxt_s    = pc_r;
                        skid_instr_nxt_s = imem_rdata;
                        pc_nxt_s         = pc_plus4_s;
                        state_nxt_s      = ST_HOLD;
                    end else begin
                        if_valid_nxt_s    = 1'b1;
                        if_pc_nxt_s       = pc_r;
                        if_instr_nxt_s    = imem_rdata;
                        if_pc_plus4_nxt_s = pc_plus4_s;
                        pc_nxt_s          = pc_plus4_s;
                    end
                end else begin
                    if (redir_s) begin
                        // Request still in flight: keep the address, remember where to go.
                        pend_valid_nxt_s = 1'b1;
                        pend_pc_nxt_s    = tgt_s;
                        if_valid_nxt_s   = 1'b0;
                    end else if (!stall) begin
                        if_valid_nxt_s = 1'b0;
                    end else begin
                        if_valid_nxt_s = if_valid_r;
                    end
                end
            end

            ST_HOLD: begin
                if (redir_s) begin
                    pc_nxt_s         = tgt_s;
                    pend_valid_nxt_s = 1'b0;
                    skid_valid_nxt_s = 1'b0;
                    if_valid_nxt_s   = 1'b0;
                    state_nxt_s      = ST_REQ;
                end else if (!stall) begin
                    if_valid_nxt_s    = skid_valid_r;
                    if_pc_nxt_s       = skid_pc_r;
                    if_instr_nxt_s    = skid_instr_r;
                    if_pc_plus4_nxt_s = skid_pc_plus4_s;
                    skid_valid_nxt_s  = 1'b0;
                    state_nxt_s       = ST_REQ;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC, pending redirect, skid buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            imem_req_r    <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_pc_r     <= 32'h0000_0000;
            skid_valid_r  <= 1'b0;
            skid_pc_r     <= 32'h0000_0000;
            skid_instr_r  <= 32'h0000_0000;
            if_valid_r    <= 1'b0;
            if_pc_r       <= 32'h0000_0000;
            if_instr_r    <= 32'h0000_0000;
            if_pc_plus4_r <= 32'h0000_0000;
            misalign_r    <= 1'b0;
        end else begin
            pc_r          <= pc_nxt_s;
            imem_req_r    <= (state_nxt_s == ST_REQ);
            pend_valid_r  <= pend_valid_nxt_s;
            pend_pc_r     <= pend_pc_nxt_s;
            skid_valid_r  <= skid_valid_nxt_s;
            skid_pc_r     <= skid_pc_nxt_s;
            skid_instr_r  <= skid_instr_nxt_s;
            if_valid_r    <= if_valid_nxt_s;
            if_pc_r       <= if_pc_nxt_s;
            if_instr_r    <= if_instr_nxt_s;
            if_pc_plus4_r <= if_pc_plus4_nxt_s;
            misalign_r    <= misal_s;
        end
    end

    assign imem_req     = imem_req_r;
    assign imem_addr    = pc_r;
    assign if_valid     = if_valid_r;
    assign if_pc        = if_pc_r;
    assign if_instr     = if_instr_r;
    assign if_pc_plus4  = if_pc_plus4_r;
    assign misalign_exc = misalign_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level fetch model kept in this file.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_0080;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        misalign_exc;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = just out of reset, 1 = fetching, 2 = parked on a stalled word.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    logic [63:0] m_skid[$];
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic        e_misal;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_pc_plus4(if_pc_plus4), .misalign_exc(misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_phase = 0;
        m_pc    = RESET_PC;
        m_pend.delete();
        m_skid.delete();
        e_valid = 1'b0;
        e_pc    = 32'h0;
        e_instr = 32'h0;
        e_p4    = 32'h0;
        e_misal = 1'b0;
    endfunction

    function automatic void present(input logic [31:0] p, input logic [31:0] w);
        e_valid = 1'b1;
        e_pc    = p;
        e_instr = w;
        e_p4    = p + 32'd4;
    endfunction

    // One clock edge of fetch behaviour, expressed as prioritized spec rules.
    function automatic void model_edge();
        logic        redirect;
        logic [31:0] t;
        logic [63:0] ent;
        if (!rst_n) begin
            model_reset();
            return;
        end
        redirect = br_taken || jmp;
        t        = br_taken ? br_target : jmp_target;
        e_misal  = redirect && ((t % 32'd4) != 32'd0);
        if (e_misal) t = EXC_VEC;
        if (m_phase == 0) begin
            m_phase = 1;
            if (redirect) begin m_pc = t; e_valid = 1'b0; end
        end else if (m_phase == 2) begin
            if (redirect) begin
                m_skid.delete(); m_pc = t; e_valid = 1'b0; m_phase = 1;
            end else if (!stall) begin
                if (m_skid.size() > 0) begin
                    ent = m_skid.pop_front();
                    present(ent[63:32], ent[31:0]);
                end
                m_phase = 1;
            end
        end else begin
            if (redirect && !imem_ack) begin
                m_pend.delete(); m_pend.push_back(t); e_valid = 1'b0;
            end else if (redirect && imem_ack) begin
                m_pend.delete(); m_pc = t; e_valid = 1'b0;
            end else if (imem_ack && m_pend.size() > 0) begin
                m_pc = m_pend.pop_front();
                if (!stall) e_valid = 1'b0;
            end else if (imem_ack && stall) begin
                m_skid.push_back({m_pc, imem_rdata});
                m_pc = m_pc + 32'd4;
                m_phase = 2;
            end else if (imem_ack) begin
                present(m_pc, imem_rdata);
                m_pc = m_pc + 32'd4;
            end else if (!stall) begin
                e_valid = 1'b0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; imem_ack = 1'b0;
        br_target = 32'h0; jmp_target = 32'h0; imem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        checks++;
        if ({imem_req, imem_addr, if_valid, if_pc, if_instr, if_pc_plus4, misalign_exc} !== {1'b0, RESET_PC, 1'b0, 96'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got req=%b addr=%h v=%b pc=%h ins=%h p4=%h exc=%b expected all zero/RESET_PC",
                     imem_req, imem_addr, if_valid, if_pc, if_instr, if_pc_plus4, misalign_exc);
        end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        checks++;
        if ({imem_req, if_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_ack_ignored: got req=%b v=%b expected 0 0", imem_req, if_valid);
        end
        imem_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL idle_no_req: got %b expected 0", imem_req);
        end
        step();
        checks++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, RESET_PC, 1'b0}) begin
            errors++; $display("FAIL idle_to_req: got req=%b addr=%h v=%b expected 1 %h 0", imem_req, imem_addr, if_valid, RESET_PC);
        end
    endtask

    task automatic test_seq();
        do_reset();
        imem_ack = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            imem_rdata = 32'hC0DE_0000 | imem_addr;
            step();
            checks++;
            if (imem_addr !== 32'(4 * (n - 1))) begin
                errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", n, imem_addr, 32'(4 * (n - 1)));
            end
            if (n >= 2) begin
                checks++;
                if ({if_valid, if_pc, if_instr, if_pc_plus4} !== {1'b1, 32'(4 * (n - 2)), 32'hC0DE_0000 | 32'(4 * (n - 2)), 32'(4 * (n - 1))}) begin
                    errors++; $display("FAIL seq_bundle[%0d]: got v=%b pc=%h ins=%h p4=%h expected pc=%h", n, if_valid, if_pc, if_instr, if_pc_plus4, 32'(4 * (n - 2)));
                end
            end
        end
    endtask

    task automatic test_ack_delay();
        do_reset();
        imem_ack = 1'b1;
        repeat (5) begin imem_rdata = 32'hC0DE_0000 | imem_addr; step(); end
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h10, 1'b0}) begin
                errors++; $display("FAIL delay_wait[%0d]: got req=%b addr=%h v=%b expected 1 00000010 0", k, imem_req, imem_addr, if_valid);
            end
        end
        imem_ack = 1'b1; imem_rdata = 32'hC0DE_0010;
        step();
        checks++;
        if ({imem_addr, if_valid, if_pc, if_instr} !== {32'h14, 1'b1, 32'h10, 32'hC0DE_0010}) begin
            errors++; $display("FAIL delay_bundle: got addr=%h v=%b pc=%h ins=%h expected 14 1 10 c0de0010", imem_addr, if_valid, if_pc, if_instr);
        end
        imem_ack = 1'b0;
        step();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++; $display("FAIL delay_single: got v=%b expected 0", if_valid);
        end
    endtask

    task automatic test_branch_pending();
        do_reset();
        imem_ack = 1'b1;
        repeat (6) begin imem_rdata = 32'hC0DE_0000 | imem_addr; step(); end
        imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h200;
        step();
        checks++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h14, 1'b0}) begin
            errors++; $display("FAIL br_pending_hold: got req=%b addr=%h v=%b expected 1 00000014 0", imem_req, imem_addr, if_valid);
        end
        br_taken = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0014;
        step();
        checks++;
        if ({imem_addr, if_valid} !== {32'h200, 1'b0}) begin
            errors++; $display("FAIL br_discard: got addr=%h v=%b expected 00000200 0", imem_addr, if_valid);
        end
        imem_rdata = 32'hC0DE_0200;
        step();
        checks++;
        if ({imem_addr, if_valid, if_pc, if_instr} !== {32'h204, 1'b1, 32'h200, 32'hC0DE_0200}) begin
            errors++; $display("FAIL br_target_fetch: got addr=%h v=%b pc=%h ins=%h expected 204 1 200 c0de0200", imem_addr, if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_priority();
        br_taken = 1'b1; br_target = 32'h300; jmp = 1'b1; jmp_target = 32'h400; imem_ack = 1'b1;
        step();
        checks++;
        if ({imem_addr, if_valid, misalign_exc} !== {32'h300, 1'b0, 1'b0}) begin
            errors++; $display("FAIL priority: got addr=%h v=%b exc=%b expected 00000300 0 0", imem_addr, if_valid, misalign_exc);
        end
        br_taken = 1'b0; jmp = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_stall_hold();
        jmp = 1'b1; jmp_target = 32'h20; imem_ack = 1'b1;
        step();
        jmp = 1'b0; stall = 1'b1; imem_rdata = 32'hDEAD_0020;
        step();
        checks++;
        if ({imem_req, if_valid, if_pc, if_instr, if_pc_plus4} !== {1'b0, e_valid, e_pc, e_instr, e_p4} || if_valid !== 1'b0) begin
            errors++; $display("FAIL stall_hold1: got req=%b v=%b pc=%h expected req=0 v=0 pc=%h", imem_req, if_valid, if_pc, e_pc);
        end
        imem_rdata = 32'h1111_1111;
        step();
        checks++;
        if ({imem_req, if_valid, if_pc, if_instr, if_pc_plus4} !== {1'b0, e_valid, e_pc, e_instr, e_p4}) begin
            errors++; $display("FAIL stall_hold2: got req=%b v=%b pc=%h ins=%h expected req=0 held pc=%h", imem_req, if_valid, if_pc, if_instr, e_pc);
        end
        stall = 1'b0; imem_ack = 1'b0;
        step();
        checks++;
        if ({imem_req, imem_addr, if_valid, if_pc, if_instr, if_pc_plus4} !== {1'b1, 32'h24, 1'b1, 32'h20, 32'hDEAD_0020, 32'h24}) begin
            errors++; $display("FAIL stall_release: got req=%b addr=%h v=%b pc=%h ins=%h p4=%h expected 1 24 1 20 dead0020 24",
                               imem_req, imem_addr, if_valid, if_pc, if_instr, if_pc_plus4);
        end
    endtask

    task automatic test_misalign();
        jmp = 1'b1; jmp_target = 32'h402; imem_ack = 1'b1; imem_rdata = 32'h5555_0000;
        step();
        checks++;
        if ({misalign_exc, imem_addr, if_valid} !== {1'b1, EXC_VEC, 1'b0}) begin
            errors++; $display("FAIL misalign_pulse: got exc=%b addr=%h v=%b expected 1 %h 0", misalign_exc, imem_addr, if_valid, EXC_VEC);
        end
        jmp = 1'b0;
        step();
        checks++;
        if ({misalign_exc, imem_addr} !== {1'b0, EXC_VEC + 32'd4}) begin
            errors++; $display("FAIL misalign_once: got exc=%b addr=%h expected 0 %h", misalign_exc, imem_addr, EXC_VEC + 32'd4);
        end
    endtask

    task automatic test_wrap();
        jmp = 1'b1; jmp_target = 32'hFFFF_FFFC; imem_ack = 1'b1;
        step();
        jmp = 1'b0; imem_rdata = 32'hFEED_FFFC;
        step();
        checks++;
        if ({imem_addr, if_valid, if_pc, if_pc_plus4} !== {32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            errors++; $display("FAIL pc_wrap: got addr=%h v=%b pc=%h p4=%h expected 0 1 fffffffc 0", imem_addr, if_valid, if_pc, if_pc_plus4);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b0;
        step();
        #2;
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h9999_9999;
        model_reset();
        #1;
        checks++;
        if ({imem_req, imem_addr, if_valid, if_pc} !== {1'b0, RESET_PC, 1'b0, 32'h0}) begin
            errors++; $display("FAIL reset_async: got req=%b addr=%h v=%b pc=%h expected 0 %h 0 0", imem_req, imem_addr, if_valid, if_pc, RESET_PC);
        end
        step();
        step();
        checks++;
        if ({imem_req, if_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_ack_during: got req=%b v=%b expected 0 0", imem_req, if_valid);
        end
        rst_n = 1'b1;
        step();
        imem_rdata = 32'hC0DE_0000;
        step();
        checks++;
        if ({imem_addr, if_valid, if_pc, if_instr} !== {RESET_PC + 32'd4, 1'b1, RESET_PC, 32'hC0DE_0000}) begin
            errors++; $display("FAIL reset_restart: got addr=%h v=%b pc=%h ins=%h expected 4 1 0 c0de0000", imem_addr, if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_random();
        logic [130:0] exp_b;
        logic [130:0] act_b;
        logic [31:0]  t;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            stall      = ($urandom_range(0, 9) < 3);
            imem_ack   = ($urandom_range(0, 9) < 6);
            imem_rdata = $urandom();
            br_taken   = ($urandom_range(0, 99) < 8);
            jmp        = ($urandom_range(0, 99) < 8);
            t = $urandom();
            t[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
            br_target = t;
            t = $urandom();
            t[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            jmp_target = t;
            step();
            exp_b = {(m_phase == 1), m_pc, e_valid, e_pc, e_instr, e_p4, e_misal};
            act_b = {imem_req, imem_addr, if_valid, if_pc, if_instr, if_pc_plus4, misalign_exc};
            checks++;
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL random[%0d]: got req=%b addr=%h v=%b pc=%h ins=%h p4=%h exc=%b expected req=%b addr=%h v=%b pc=%h ins=%h p4=%h exc=%b",
                         c, imem_req, imem_addr, if_valid, if_pc, if_instr, if_pc_plus4, misalign_exc,
                         exp_b[130], m_pc, e_valid, e_pc, e_instr, e_p4, e_misal);
            end
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_seq();
        test_ack_delay();
        test_branch_pending();
        test_priority();
        test_stall_hold();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter EXC_VEC, default 32'h0000_0080, SHALL be the PC loaded on a misaligned redirect.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 stall  input  1  SHALL be the hazard-unit stall request, where 1 means decode does not accept if_*.
REQ-006 br_taken  input  1  /  br_target  input  32  SHALL carry the branch redirect request and its target.
REQ-007 jmp  input  1  /  jmp_target  input  32  SHALL carry the j/jal/jr redirect request and its target.
REQ-008 imem_req  output  1  /  imem_addr  output  32  SHALL carry the instruction-memory read request and its address.
REQ-009 imem_ack  input  1  /  imem_rdata  input  32  SHALL indicate that read data is valid this cycle and carry that data.
REQ-010 if_valid  output  1  /  if_pc  output  32  /  if_instr  output  32  /  if_pc_plus4  output  32  SHALL form the fetch-to-decode bundle.
REQ-011 misalign_exc  output  1  SHALL be a one-cycle pulse on a misaligned redirect target.

Function
REQ-012 The block SHALL implement the states IDLE, REQ and HOLD.
REQ-013 IDLE SHALL last one cycle after reset release and then transition to REQ.
REQ-014 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal the PC register.
- imem_addr SHALL stay stable until imem_ack.
REQ-015 When imem_ack arrives in REQ with stall=0 and no redirect, the next cycle SHALL show:
- if_valid=1, if_pc=PC, if_instr=imem_rdata, if_pc_plus4=PC+4;
- PC <= PC+4;
- the FSM remains in REQ.
REQ-016 When imem_ack arrives in REQ with stall=1, imem_rdata SHALL be captured in a one-entry skid buffer and the FSM SHALL enter HOLD.
- In HOLD, imem_req SHALL be 0 and the if_* outputs SHALL hold their values.
REQ-017 When stall falls in HOLD, the skid entry SHALL be presented on if_* in the next cycle and the FSM SHALL return to REQ.
REQ-018 While stall=1, the if_* outputs SHALL hold their values unchanged in every state.
REQ-019 If REQ has no ack and stall=0, if_valid SHALL be 0 in the next cycle.
REQ-020 PC+4 SHALL use 32-bit modulo arithmetic: 32'hFFFF_FFFC+4 = 32'h0000_0000, with the carry discarded.
REQ-021 Redirect priority SHALL be br_taken > jmp > sequential.
REQ-022 A redirect SHALL be honored regardless of stall.
REQ-023 A redirect with no request outstanding SHALL load PC <= target next cycle and set if_valid=0 next cycle (flush).
REQ-024 A redirect while a request is outstanding SHALL behave as follows:
- the target is latched as a pending redirect;
- the outstanding request completes with imem_addr unchanged;
- the returned word is discarded, with if_valid=0;
- PC <= pending target.
REQ-025 A redirect in the same cycle as imem_ack SHALL discard the acked word and set PC <= target.
REQ-026 A later redirect SHALL overwrite an earlier pending redirect.
REQ-027 A redirect in HOLD SHALL discard the skid entry, set PC <= target and return the FSM to REQ.
REQ-028 A target with target[1:0]!=0 SHALL cause:
- misalign_exc=1 for one cycle;
- PC <= EXC_VEC, with the target ignored;
- the same flush rules as a normal redirect.
REQ-029 imem_ack SHALL be ignored in IDLE and HOLD.

Reset
REQ-030 While rst_n=0, the block SHALL hold:
- PC=RESET_PC, FSM=IDLE;
- imem_req=0, imem_addr=RESET_PC;
- if_valid=0, if_pc=0, if_instr=0, if_pc_plus4=0;
- misalign_exc=0, pending redirect cleared, skid buffer empty.
REQ-031 Reset assertion mid-transaction SHALL abandon the outstanding request immediately, and an ack arriving during reset SHALL be ignored.

Verification
REQ-032 Reset release with ack tied to 1 every cycle -> imem_addr SHALL read 0, 4, 8, ..., with if_pc trailing imem_addr by one cycle and if_valid=1 from the second fetch cycle.
REQ-033 Ack delayed 3 cycles at PC 0x10 -> imem_addr SHALL stay 0x10 for all 4 cycles, if_valid SHALL be 0 during the wait, and a single valid 0x10 bundle SHALL follow.
REQ-034 br_taken=1 with target 0x200 one cycle before the ack of 0x14 -> the 0x14 word SHALL be discarded and the next imem_addr SHALL be 0x200.
REQ-035 br_taken=1 (0x300) and jmp=1 (0x400) in the same cycle -> the next imem_addr SHALL be 0x300.
REQ-036 stall=1 over the ack of 0x20, held for 2 cycles -> the FSM SHALL be in HOLD, imem_req=0 and if_* held; after stall falls, if_pc=0x20 and if_instr equals the captured word.
REQ-037 jmp_target=0x402 -> misalign_exc SHALL pulse for 1 cycle and the next imem_addr SHALL be 0x80.
